// File: rtl/xor_parity_misr.sv
// ============================================================================
// Module   : xor_parity_misr
// Brief    : Interleaved group parity through a 2-stage registered XOR tree,
//            with optional MISR signature fold and saturating beat counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_parity_misr #(
    parameter int WIDTH   = 32,
    parameter int NGROUPS = 8,
    parameter int INVERT  = 0,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_mode,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NGROUPS-1:0] out_parity,
    output logic [NGROUPS-1:0] out_sig,
    output logic [CNT_W-1:0]   beat_cnt
);

    localparam int                 c_GBITS    = WIDTH / NGROUPS;
    localparam int                 c_LO_BITS  = c_GBITS / 2;
    localparam logic [NGROUPS-1:0] c_INV_MASK = (INVERT != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NGROUPS-1:0] w_lo;
    logic [NGROUPS-1:0] w_hi;
    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_out_acc;

    logic [NGROUPS-1:0] r_s1_lo;
    logic [NGROUPS-1:0] r_s1_hi;
    logic               r_s1_mode;
    logic               r_s1_valid;
    logic [NGROUPS-1:0] r_s2_par;
    logic               r_s2_mode;
    logic               r_s2_valid;
    logic [NGROUPS-1:0] r_sig;
    logic [CNT_W-1:0]   r_cnt;

    // Group g collects bits g, g+NGROUPS, g+2*NGROUPS, ...; the first half of
    // those bits forms the lower partial, the rest the upper partial.
    always_comb begin
        w_lo = '0;
        w_hi = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            for (int j = 0; j < c_GBITS; j++) begin
                if (j < c_LO_BITS) begin
                    w_lo[g] = w_lo[g] ^ in_data[j*NGROUPS + g];
                end else begin
                    w_hi[g] = w_hi[g] ^ in_data[j*NGROUPS + g];
                end
            end
        end
    end

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_out_acc = r_s2_valid && out_ready;
    assign in_ready  = w_s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_lo    <= '0;
            r_s1_hi    <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_lo   <= w_lo;
                r_s1_hi   <= w_hi;
                r_s1_mode <= in_mode;
            end
        end
    end

    // Parity only updates on a real beat so it holds while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_par   <= '0;
            r_s2_mode  <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_par  <= r_s1_lo ^ r_s1_hi ^ c_INV_MASK;
                r_s2_mode <= r_s1_mode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_sig <= '0;
            r_cnt <= '0;
        end else if (w_out_acc) begin
            if (r_s2_mode) begin
                r_sig <= {r_sig[NGROUPS-2:0], r_sig[NGROUPS-1]} ^ r_s2_par;
            end
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_parity = r_s2_par;
    assign out_sig    = r_sig;
    assign beat_cnt   = r_cnt;

endmodule

`default_nettype wire
